// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the multi-cycle ALU.
//   op_t    - 3-bit operation code (AND/OR/ADD/SUB/XOR/MUL, two reserved codes)
//   state_t - controller state (IDLE/BUSY/DONE)
package alu_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_XOR  = 3'b100,
    OP_MUL  = 3'b101,
    OP_RSV6 = 3'b110,
    OP_RSV7 = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_comb.sv
// alu_comb: combinational logic unit for the single-cycle operations.
//   op    - operation code (MUL and reserved codes give all-zero results)
//   a, b  - operands
//   o     - result
//   cout  - carry out of the MSB (ADD), no-borrow flag (SUB), else 0
//   ovf   - two's-complement overflow (ADD/SUB), else 0
module alu_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  op_t              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] o,
  output logic             cout,
  output logic             ovf
);

  logic             is_sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum;
  logic [WIDTH:0]   c;

  // SUB reuses the adder as a + ~b + 1: invert b and inject the +1 as carry-in.
  assign is_sub = (op == OP_SUB);
  assign c[0]   = is_sub;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_slice
      assign b_eff[gi]  = b[gi] ^ is_sub;
      assign sum[gi]    = a[gi] ^ b_eff[gi] ^ c[gi];
      assign c[gi+1]    = (a[gi] & b_eff[gi]) | (c[gi] & (a[gi] ^ b_eff[gi]));
    end
  endgenerate

  always_comb begin
    o    = '0;
    cout = 1'b0;
    ovf  = 1'b0;
    case (op)
      OP_AND: o = a & b;
      OP_OR:  o = a | b;
      OP_XOR: o = a ^ b;
      OP_ADD, OP_SUB: begin
        o    = sum;
        cout = c[WIDTH];
        // Carry into the MSB differing from carry out of it means signed overflow.
        ovf  = c[WIDTH] ^ c[WIDTH-1];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with valid/ready handshakes on both sides.
//   clk, reset           - clock and synchronous active-high reset
//   in_valid / in_ready  - operation offer / acceptance (accepted only in IDLE)
//   op, i0, i1           - operation code and operands, captured at acceptance
//   out_valid/out_ready  - result available / consumer takes it
//   o, cout, zero, neg, ovf - registered result and status flags
// Single-cycle ops resolve on the accepting edge; MUL runs WIDTH shift-add
// iterations in BUSY and enters DONE on the edge of the last iteration.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] o,
  output logic             cout,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t             state_q, state_d;
  op_t                op_q, op_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;    // shifts right, LSB selects the add
  logic [2*WIDTH-1:0] mplier_q, mplier_d;  // shifts left, already aligned
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   o_q, o_d;
  logic               cout_q, cout_d;
  logic               zero_q, zero_d;
  logic               neg_q, neg_d;
  logic               ovf_q, ovf_d;

  op_t              op_in;
  logic [WIDTH-1:0] comb_o;
  logic             comb_cout;
  logic             comb_ovf;

  assign op_in = op_t'(op);

  // Fed from the live inputs: it is only consulted on the accepting edge,
  // when the inputs are exactly the values being captured.
  alu_comb #(.WIDTH(WIDTH)) u_comb (
    .op   (op_in),
    .a    (i0),
    .b    (i1),
    .o    (comb_o),
    .cout (comb_cout),
    .ovf  (comb_ovf)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    o_d      = o_q;
    cout_d   = cout_q;
    zero_d   = zero_q;
    neg_d    = neg_q;
    ovf_d    = ovf_q;
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d     = op_in;
          mcand_d  = i0;
          mplier_d = {{WIDTH{1'b0}}, i1};
          acc_d    = '0;
          cnt_d    = '0;
          if (op_in == OP_MUL) begin
            state_d = BUSY;
          end else begin
            state_d = DONE;
            o_d     = comb_o;
            cout_d  = comb_cout;
            ovf_d   = comb_ovf;
            zero_d  = (comb_o == '0);
            neg_d   = comb_o[WIDTH-1];
          end
        end
      end

      BUSY: begin
        if (op_q == OP_MUL) begin
          if (mcand_q[0]) begin
            acc_d = acc_q + mplier_q;
          end
          mcand_d  = mcand_q >> 1;
          mplier_d = mplier_q << 1;
          cnt_d    = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d = DONE;
            o_d     = acc_d[WIDTH-1:0];
            cout_d  = |acc_d[2*WIDTH-1:WIDTH];
            ovf_d   = |acc_d[2*WIDTH-1:WIDTH];
            zero_d  = (acc_d[WIDTH-1:0] == '0);
            neg_d   = acc_d[WIDTH-1];
          end
        end else begin
          // Unreachable for a legal capture; recover rather than stall.
          state_d = IDLE;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= OP_AND;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      o_q      <= '0;
      cout_q   <= 1'b0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      o_q      <= o_d;
      cout_q   <= cout_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
      ovf_q    <= ovf_d;
    end
  end

  assign o    = o_q;
  assign cout = cout_q;
  assign zero = zero_q;
  assign neg  = neg_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: self-checking bench for alu_mc at WIDTH=16 and WIDTH=8.
module tb_alu_mc;

  typedef struct {
    logic [15:0] o;
    logic        cout;
    logic        zero;
    logic        neg;
    logic        ovf;
  } exp_t;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    exp_t        e;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // WIDTH=16 instance
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [15:0] i0 = '0, i1 = '0, o;
  logic        cout, zero, neg, ovf;

  // WIDTH=8 instance
  logic        in_valid8 = 1'b0, in_ready8, out_valid8, out_ready8 = 1'b0;
  logic [2:0]  op8 = 3'd0;
  logic [7:0]  a8 = '0, b8 = '0, o8;
  logic        cout8, zero8, neg8, ovf8;

  int n_cmp = 0;
  int n_bad = 0;

  alu_mc #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .i0(i0), .i1(i1), .out_valid(out_valid), .out_ready(out_ready),
    .o(o), .cout(cout), .zero(zero), .neg(neg), .ovf(ovf)
  );

  alu_mc #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
    .op(op8), .i0(a8), .i1(b8), .out_valid(out_valid8), .out_ready(out_ready8),
    .o(o8), .cout(cout8), .zero(zero8), .neg(neg8), .ovf(ovf8)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on w-bit values.
  function automatic exp_t ref_calc(input logic [2:0] opc, input longint unsigned a,
                                    input longint unsigned b, input int w);
    exp_t r;
    longint unsigned mask, s, p;
    bit sa, sb, so;
    mask = (64'd1 << w) - 1;
    a = a & mask;
    b = b & mask;
    r.o = '0; r.cout = 0; r.ovf = 0;
    sa = a[w-1];
    sb = b[w-1];
    case (opc)
      3'd0: r.o = 16'(a & b);
      3'd1: r.o = 16'(a | b);
      3'd4: r.o = 16'(a ^ b);
      3'd2: begin
        s = a + b;
        r.o = 16'(s & mask);
        r.cout = ((s >> w) & 1) != 0;
        so = ((s >> (w - 1)) & 1) != 0;
        r.ovf = (sa == sb) && (so != sa);
      end
      3'd3: begin
        s = a + ((~b) & mask) + 1;
        r.o = 16'(s & mask);
        r.cout = (a >= b);
        so = ((s >> (w - 1)) & 1) != 0;
        r.ovf = (sa != sb) && (so != sa);
      end
      3'd5: begin
        p = a * b;
        r.o = 16'(p & mask);
        r.cout = (p >> w) != 0;
        r.ovf = r.cout;
      end
      default: ;
    endcase
    r.zero = (r.o == 0);
    r.neg  = ((longint'(r.o) >> (w - 1)) & 1) != 0;
    return r;
  endfunction

  // One 16-bit transaction; entered and left at posedge+1 with the DUT in IDLE.
  task automatic do_op(input string name, input logic [2:0] opc, input logic [15:0] a,
                       input logic [15:0] b, input exp_t e, input int hold, input bit pulse);
    int lat;
    int exp_lat;
    logic [15:0] o_seen;
    exp_lat = (opc == 3'd5) ? 17 : 1;
    chk({name, " in_ready idle"}, 64'(in_ready), 64'd1);
    op = opc; i0 = a; i1 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op = 3'($urandom); i0 = 16'($urandom); i1 = 16'($urandom);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({name, " latency"}, 64'(lat), 64'(exp_lat));
    chk({name, " o"}, 64'(o), 64'(e.o));
    chk({name, " cout"}, 64'(cout), 64'(e.cout));
    chk({name, " zero"}, 64'(zero), 64'(e.zero));
    chk({name, " neg"}, 64'(neg), 64'(e.neg));
    chk({name, " ovf"}, 64'(ovf), 64'(e.ovf));
    o_seen = o;
    for (int k = 0; k < hold; k++) begin
      if (pulse) begin
        in_valid = 1'b1; op = 3'd2; i0 = 16'($urandom); i1 = 16'($urandom);
      end
      @(posedge clk); #1;
      chk({name, " hold o"}, 64'(o), 64'(o_seen));
      chk({name, " hold in_ready"}, 64'(in_ready), 64'd0);
      chk({name, " hold out_valid"}, 64'(out_valid), 64'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({name, " consumed out_valid"}, 64'(out_valid), 64'd0);
    chk({name, " consumed in_ready"}, 64'(in_ready), 64'd1);
    $display("W16 %-10s op=%0d a=%h b=%h o=%h c=%0b z=%0b n=%0b v=%0b lat=%0d",
             name, opc, a, b, o_seen, cout, zero, neg, ovf, lat);
  endtask

  task automatic do_op8(input string name, input logic [2:0] opc, input logic [7:0] a,
                        input logic [7:0] b);
    int lat;
    exp_t e;
    e = ref_calc(opc, 64'(a), 64'(b), 8);
    op8 = opc; a8 = a; b8 = b; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    lat = 1;
    while (!out_valid8 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({name, " latency"}, 64'(lat), (opc == 3'd5) ? 64'd9 : 64'd1);
    chk({name, " o"}, 64'(o8), 64'(e.o[7:0]));
    chk({name, " cout"}, 64'(cout8), 64'(e.cout));
    chk({name, " zero"}, 64'(zero8), 64'(e.zero));
    chk({name, " neg"}, 64'(neg8), 64'(e.neg));
    chk({name, " ovf"}, 64'(ovf8), 64'(e.ovf));
    $display("W8  %-10s op=%0d a=%h b=%h o=%h c=%0b z=%0b n=%0b v=%0b lat=%0d",
             name, opc, a, b, o8, cout8, zero8, neg8, ovf8, lat);
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
    chk({name, " consumed in_ready"}, 64'(in_ready8), 64'd1);
  endtask

  task automatic chk_reset_state(input string name);
    chk({name, " in_ready"}, 64'(in_ready), 64'd1);
    chk({name, " out_valid"}, 64'(out_valid), 64'd0);
    chk({name, " o"}, 64'(o), 64'd0);
    chk({name, " flags"}, 64'({cout, zero, neg, ovf}), 64'd0);
  endtask

  vec_t tbl[13];

  initial begin
    tbl[0]  = '{3'd2, 16'h7FFF, 16'h0001, '{16'h8000, 0, 0, 1, 1}};
    tbl[1]  = '{3'd3, 16'h1234, 16'h1234, '{16'h0000, 1, 1, 0, 0}};
    tbl[2]  = '{3'd3, 16'h0000, 16'h0001, '{16'hFFFF, 0, 0, 1, 0}};
    tbl[3]  = '{3'd5, 16'h0100, 16'h0100, '{16'h0000, 1, 1, 0, 1}};
    tbl[4]  = '{3'd5, 16'h00FF, 16'h0003, '{16'h02FD, 0, 0, 0, 0}};
    tbl[5]  = '{3'd0, 16'hF0F0, 16'h0FF0, '{16'h00F0, 0, 0, 0, 0}};
    tbl[6]  = '{3'd1, 16'hF0F0, 16'h0FF0, '{16'hFFF0, 0, 0, 1, 0}};
    tbl[7]  = '{3'd4, 16'hF0F0, 16'h0FF0, '{16'hFF00, 0, 0, 1, 0}};
    tbl[8]  = '{3'd6, 16'hABCD, 16'h1234, '{16'h0000, 0, 1, 0, 0}};
    tbl[9]  = '{3'd7, 16'hFFFF, 16'hFFFF, '{16'h0000, 0, 1, 0, 0}};
    tbl[10] = '{3'd2, 16'hFFFF, 16'h0001, '{16'h0000, 1, 1, 0, 0}};
    tbl[11] = '{3'd3, 16'h8000, 16'h0001, '{16'h7FFF, 1, 0, 0, 1}};
    tbl[12] = '{3'd5, 16'hFFFF, 16'hFFFF, '{16'h0001, 1, 0, 0, 1}};

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk_reset_state("reset");
    chk("reset8 state", 64'({in_ready8, out_valid8, o8, cout8, zero8, neg8, ovf8}),
        64'({1'b1, 1'b0, 8'h00, 4'b0000}));

    for (int k = 0; k < 13; k++) begin
      do_op($sformatf("vec%0d", k), tbl[k].op, tbl[k].a, tbl[k].b, tbl[k].e, 0, 1'b0);
    end

    // Backpressure with dropped offers in the DONE window.
    do_op("bp_add", 3'd2, 16'h1111, 16'h2222, '{16'h3333, 0, 0, 0, 0}, 5, 1'b1);
    chk("bp no queued op", 64'(out_valid), 64'd0);

    // Reset abort four cycles into a MUL.
    op = 3'd5; i0 = 16'h1234; i1 = 16'h5678; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk_reset_state("abort");
    repeat (20) @(posedge clk);
    #1;
    chk("abort no out_valid", 64'(out_valid), 64'd0);
    do_op("post_abort", 3'd0, 16'hF0F0, 16'h0FF0, '{16'h00F0, 0, 0, 0, 0}, 0, 1'b0);

    // Randomized against the model.
    for (int k = 0; k < 40; k++) begin
      logic [2:0]  r_op;
      logic [15:0] r_a, r_b;
      r_op = 3'($urandom_range(0, 7));
      r_a  = 16'($urandom);
      r_b  = 16'($urandom);
      if (k % 4 == 0) r_b = r_a;
      do_op($sformatf("rnd%0d", k), r_op, r_a, r_b, ref_calc(r_op, 64'(r_a), 64'(r_b), 16),
            int'($urandom_range(0, 2)), 1'b0);
    end

    // WIDTH=8 build.
    do_op8("w8_add", 3'd2, 8'hFF, 8'h01);
    do_op8("w8_mul", 3'd5, 8'h0F, 8'h11);
    do_op8("w8_mulov", 3'd5, 8'hF0, 8'h10);
    do_op8("w8_sub", 3'd3, 8'h80, 8'h01);
    for (int k = 0; k < 10; k++) begin
      do_op8($sformatf("w8_rnd%0d", k), 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised multi-cycle ALU with valid/ready handshakes on both sides. It succeeds the fixed 16-bit ripple ALU and adds:
- configurable width;
- XOR and unsigned shift-add multiply;
- registered result and status flags;
- a three-state controller that accepts one operation at a time.

It sits between the operand registers and the writeback path of the lab datapath.

## Interface
- WIDTH, 16: operand and result width in bits; must be ≥ 2.
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  an operation is offered.
- in_ready  output  1  the block can accept an operation.
- op  input  3  operation code, encoded in alu_pkg.
- i0  input  WIDTH  operand A.
- i1  input  WIDTH  operand B.
- out_valid  output  1  result and flags are valid.
- out_ready  input  1  the consumer takes the result.
- o  output  WIDTH  result.
- cout  output  1  carry out, or multiply high-half nonzero.
- zero  output  1  o == 0.
- neg  output  1  o[WIDTH-1].
- ovf  output  1  signed overflow (ADD/SUB), or multiply overflow.

## Operation
- Op codes:
  - 000 AND, 001 OR, 010 ADD, 011 SUB, 100 XOR, 101 MUL.
  - 110 and 111 are reserved. They execute as single-cycle ops with o=0, cout=0, ovf=0, zero=1, neg=0.
- States are IDLE, BUSY and DONE. Reset enters IDLE.
  - IDLE: in_ready=1. On in_valid, latch op, i0 and i1.
    - MUL goes to BUSY.
    - Every other op computes from the latched operands and goes to DONE.
  - BUSY: one multiplier bit per cycle.
    - If mcand bit k is 1, add the shifted multiplier into a 2·WIDTH accumulator.
    - Go to DONE after exactly WIDTH iterations.
  - DONE: out_valid=1, and o and the flags are stable. When out_ready=1, return to IDLE.
- Arithmetic:
  - ADD is i0+i1 mod 2^WIDTH. cout is the carry out of the MSB.
  - SUB is i0+~i1+1. cout=1 means no borrow (i0 ≥ i1 unsigned).
  - ovf for ADD/SUB is the standard two's-complement rule: carry into the MSB XOR carry out of the MSB.
  - AND, OR and XOR give cout=0 and ovf=0.
  - MUL is unsigned. o is product[WIDTH-1:0]. cout = ovf = |product[2·WIDTH-1:WIDTH].
  - zero and neg are always derived from o.
- Operands are captured at acceptance. Later changes on i0, i1 or op have no effect until the next acceptance.
- in_ready is 0 in BUSY and DONE. There is no skid buffer.
- Reset overrides everything, including reset during BUSY or DONE:
  - go to IDLE;
  - clear the accumulator and counter;
  - no out_valid is produced for the aborted operation.

## Timing
- Values after reset: in_ready=1, out_valid=0, o=0, cout=0, zero=0, neg=0, ovf=0.
- Single-cycle ops are accepted at edge N. out_valid=1 from edge N+1.
- MUL is accepted at edge N. out_valid=1 from edge N+WIDTH+1.
- out_valid and the outputs hold across any number of out_ready=0 cycles.
- Handshake on the result side:
  - The result is consumed at the first edge with out_valid && out_ready.
  - in_ready=1 from the following cycle.
  - Peak throughput is one single-cycle op per 2 clocks.
- in_valid while in_ready=0 is ignored. The offer is not queued.
- o and the flags change only on the edge entering DONE, or on reset.

## Structure
- Package alu_pkg holds:
  - the op_t 3-bit enum with the codes above;
  - the state_t enum IDLE/BUSY/DONE.
- Sub-module alu_comb, parametrised by WIDTH, is purely combinational. It implements AND/OR/ADD/SUB/XOR and produces o, cout and ovf using the per-bit add/sub slice style.
- alu_mc holds:
  - the controller;
  - the operand registers;
  - the MUL accumulator and the $clog2(WIDTH+1)-bit iteration counter;
  - the output registers.

## Test plan
- ADD overflow, WIDTH=16: i0=16'h7FFF, i1=16'h0001 → o=16'h8000, cout=0, ovf=1, neg=1, zero=0. out_valid rises 1 cycle after acceptance.
- SUB equal operands: i0=16'h1234, i1=16'h1234 → o=0, zero=1, cout=1, ovf=0.
- SUB with borrow: i0=16'h0000, i1=16'h0001 → o=16'hFFFF, cout=0, ovf=0, neg=1.
- MUL overflow: i0=16'h0100, i1=16'h0100 → o=0, cout=1, ovf=1, zero=1. out_valid exactly 17 cycles after acceptance.
- MUL without overflow: 16'h00FF × 16'h0003 → o=16'h02FD, cout=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → outputs unchanged and in_ready=0 throughout. An in_valid pulse in that window is dropped.
- Reset abort: assert reset 4 cycles into a MUL → the next cycle shows in_ready=1 and out_valid=0, all outputs 0. The following AND 16'hF0F0 & 16'h0FF0 → o=16'h00F0.
- WIDTH=8 build: 8'hFF + 8'h01 → o=0, cout=1, zero=1, ovf=0. MUL latency is 9 cycles.
